// File: rtl/myuart_rx_os_pkg.sv
// Shared UART definitions: receiver FSM state codes, frame width, baud divider helper.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
package myuart_rx_os_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DATA_BITS = 8;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = (clk_freq + (baud * os) / 2) / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/myuart_baud_tick.sv
// Oversample tick prescaler: counts 0..DIV-1, tick asserted while the count sits at DIV-1.
// Latency: first tick DIV clocks after a synchronous clear.
// Backpressure: none; free-running unless cleared.
module myuart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/myuart_rx_os.sv
// 8N1 oversampled UART receiver with majority-vote mid-bit sampling, framing and overrun flags.
// Latency: rx_valid rises one clk after the mid-stop-bit decision (~9.5 bit times after start edge).
// Backpressure: rx_valid held until rx_ready; a new byte overwrites an unaccepted one and pulses overrun.
module myuart_rx_os
  import myuart_rx_os_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_M_LO = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_M    = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_M_HI = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  logic                 meta_q, meta_d;
  logic                 rxd_s_q, rxd_s_d;
  logic                 rxd_s1_q, rxd_s1_d;
  logic [1:0]           state_q, state_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic tick, fall, start_det, maj, mid, wrap, byte_done, ferr;

  // Prescaler restarts on the start edge so ticks are phase-aligned to the frame.
  myuart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_det),
    .tick  (tick)
  );

  // Synchroniser, sampler, FSM and output register next-state logic.
  always_comb begin
    meta_d      = rxd;
    rxd_s_d     = meta_q;
    rxd_s1_d    = rxd_s_q;
    state_d     = state_q;
    sc_d        = sc_q;
    bit_d       = bit_q;
    smp_d       = smp_q;
    shreg_d     = shreg_q;
    byte_done   = 1'b0;
    ferr        = 1'b0;

    fall      = rxd_s1_q & ~rxd_s_q;
    start_det = (state_q == ST_IDLE) & fall;
    maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s_q) | (smp_q[1] & rxd_s_q);
    mid       = tick & (sc_q == SC_M_HI);
    wrap      = tick & (sc_q == SC_LAST);

    if (tick && state_q != ST_IDLE) sc_d = wrap ? '0 : sc_q + 1'b1;
    if (tick && sc_q == SC_M_LO) smp_d[0] = rxd_s_q;
    if (tick && sc_q == SC_M)    smp_d[1] = rxd_s_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          sc_d    = '0;
          bit_d   = '0;
        end
      end
      ST_START: begin
        // A start bit that reads high at mid-bit was a glitch.
        if (mid && maj)  state_d = ST_IDLE;
        else if (wrap)   state_d = ST_DATA;
      end
      ST_DATA: begin
        if (mid) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_q == BIT_LAST) state_d = ST_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      default: begin
        // Leave half a bit early so the next start edge is never missed.
        if (mid) begin
          state_d   = ST_IDLE;
          byte_done = maj;
          ferr      = ~maj;
        end
      end
    endcase

    rx_valid_d  = byte_done | (rx_valid_q & ~rx_ready);
    rx_data_d   = byte_done ? shreg_q : rx_data_q;
    overrun_d   = byte_done & rx_valid_q & ~rx_ready;
    frame_err_d = ferr;
    busy_d      = (state_d != ST_IDLE);
  end

  // State registers; synchroniser resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= 1'b1;
      rxd_s_q     <= 1'b1;
      rxd_s1_q    <= 1'b1;
      state_q     <= ST_IDLE;
      sc_q        <= '0;
      bit_q       <= '0;
      smp_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      rxd_s_q     <= rxd_s_d;
      rxd_s1_q    <= rxd_s1_d;
      state_q     <= state_d;
      sc_q        <= sc_d;
      bit_q       <= bit_d;
      smp_q       <= smp_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_myuart_rx_os.sv
// Bench for the oversampled UART receiver: frames in, scoreboard of accepts/errors out.
// Expected events are queued by a transaction-level model as frames are sent.
// A negedge monitor pops and compares whenever the DUT shows an event.
module tb_myuart_rx_os;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  localparam int BITCLK = 64;

  always #5 clk = ~clk;

  myuart_rx_os #(
    .CLK_FREQ   (6_400_000),
    .BAUD       (100_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  localparam logic [1:0] K_ACC  = 2'd0;
  localparam logic [1:0] K_FERR = 2'd1;
  localparam logic [1:0] K_OVR  = 2'd2;

  ev_t        exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         model_pending = 1'b0;
  logic [7:0] model_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] kind, input logic [7:0] data, input string name);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: unexpected event (kind %0d data %0h), nothing expected", name, kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.data !== data) begin
        n_err++;
        $display("FAIL %s: got kind %0d data %0h, expected kind %0d data %0h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every DUT event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)           pop_cmp(K_FERR, 8'h00, "frame_err");
      if (overrun)             pop_cmp(K_OVR, rx_data, "overrun");
      if (rx_valid && rx_ready) pop_cmp(K_ACC, rx_data, "accept");
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model of the consumer port: a held byte is delivered as soon as ready is high.
  task automatic set_ready(input logic v);
    rx_ready = v;
    if (v && model_pending) begin
      exp_q.push_back('{kind: K_ACC, data: model_data});
      model_pending = 1'b0;
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) exp_q.push_back('{kind: K_FERR, data: 8'h00});
    else if (rx_ready) exp_q.push_back('{kind: K_ACC, data: b});
    else begin
      if (model_pending) exp_q.push_back('{kind: K_OVR, data: b});
      model_pending = 1'b1;
      model_data    = b;
    end
  endtask

  // Drive the first nbits of {start, d0..d7, stop}; a full frame returns the line high.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bitclk, input int nbits);
    logic [9:0] bits;
    bits = {stop_v, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rxd = bits[i];
      wait_clks(bitclk);
    end
    if (nbits == 10) rxd = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input int bitclk, input int gap);
    expect_frame(b, stop_ok);
    send_frame(b, stop_ok, bitclk, 10);
    wait_clks(gap);
  endtask

  task automatic drain(input string name, input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      wait_clks(1);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d expected events never seen after %0d clks", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},   {24'd0, rx_data},   32'd0);
    check({tag, "_rx_valid"},  {31'd0, rx_valid},  32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_overrun"},   {31'd0, overrun},   32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         ok;

    wait_clks(5);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_clks(10);

    // 1: single byte, consumer always ready
    set_ready(1'b1);
    send(8'hA5, 1'b1, BITCLK, 0);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    drain("t1_drain", 200);
    wait_clks(2);
    check("t1_rx_data", {24'd0, rx_data}, 32'h0000_00A5);
    check("t1_rx_valid_low", {31'd0, rx_valid}, 32'd0);
    wait_clks(20);

    // 2: two bytes back to back with no consumer, then accept
    set_ready(1'b0);
    send(8'h3C, 1'b1, BITCLK, 0);
    send(8'hC3, 1'b1, BITCLK, 10);
    check("t2_held_data", {24'd0, rx_data}, 32'h0000_00C3);
    check("t2_held_valid", {31'd0, rx_valid}, 32'd1);
    set_ready(1'b1);
    drain("t2_drain", 200);
    wait_clks(2);
    check("t2_rx_valid_low", {31'd0, rx_valid}, 32'd0);
    wait_clks(20);

    // 3: framing error, then a good byte after the line recovers
    send(8'h55, 1'b0, BITCLK, 20);
    check("t3_no_valid", {31'd0, rx_valid}, 32'd0);
    send(8'h12, 1'b1, BITCLK, 10);
    drain("t3_drain", 200);
    check("t3_rx_data", {24'd0, rx_data}, 32'h0000_0012);
    wait_clks(20);

    // 4: short low glitch must be rejected at the start-bit mid sample
    rxd = 1'b0;
    wait_clks(20);
    rxd = 1'b1;
    check("t4_busy_in_start", {31'd0, busy}, 32'd1);
    wait_clks(60);
    check("t4_busy_idle", {31'd0, busy}, 32'd0);
    check("t4_no_valid", {31'd0, rx_valid}, 32'd0);
    drain("t4_drain", 10);

    // 5: +/-3% baud skew
    send(8'h00, 1'b1, 62, 10);
    send(8'hFF, 1'b1, 66, 10);
    send(8'hFF, 1'b1, 62, 10);
    send(8'h00, 1'b1, 66, 10);
    drain("t5_drain", 200);

    // Random frames: data, stop validity, skew, gap and consumer readiness
    for (int i = 0; i < 14; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      set_ready(1'($urandom_range(0, 1)));
      send(b, ok, $urandom_range(62, 66), $urandom_range(4, 30));
    end
    set_ready(1'b1);
    drain("rand_drain", 300);
    wait_clks(20);

    // 6: reset in the middle of data bit 4, then a clean byte
    send_frame(8'hF0, 1'b1, BITCLK, 5);
    rxd = 1'b1;
    wait_clks(BITCLK / 2);
    rst_n = 1'b0;
    model_pending = 1'b0;
    wait_clks(3);
    check_reset_outputs("t6_reset");
    wait_clks(BITCLK * 5);
    rst_n = 1'b1;
    wait_clks(10);
    check("t6_idle_after_reset", {31'd0, busy}, 32'd0);
    send(8'h81, 1'b1, BITCLK, 10);
    drain("t6_drain", 200);
    check("t6_rx_data", {24'd0, rx_data}, 32'h0000_0081);
    wait_clks(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
